// File: rtl/bias_relu_stream.sv
// Post-accumulation stage: per-channel bias add, fixed-point requantise with rounding,
// activation and output saturation over a 3-stage valid/ready pipeline.
module bias_relu_stream #(
  parameter int LANES  = 16,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int BIAS_W = 32,
  parameter int BIAS_D = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         bias_we_i,
  input  logic [$clog2(BIAS_D)-1:0]    bias_wa_i,
  input  logic [BIAS_W-1:0]            bias_wd_i,
  input  logic [3:0]                   data_bp_i,
  input  logic [3:0]                   weight_bp_i,
  input  logic [3:0]                   result_bp_i,
  input  logic                         bias_en_i,
  input  logic [1:0]                   act_mode_i,
  input  logic [$clog2(BIAS_D):0]      ch_num_i,
  input  logic [15:0]                  beats_i,
  input  logic                         start_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [LANES*ACC_W-1:0]       in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [LANES*OUT_W-1:0]       out_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int AW = $clog2(BIAS_D);
  localparam int SW = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;
  // Headroom for the largest left shift (6-bit signed amount) before saturating back to SW.
  localparam int WW = SW + 33;

  // state | meaning
  // IDLE  | waiting for start_i; zero-beat jobs complete here
  // RUN   | accepting input beats
  // DRAIN | all inputs taken, waiting for the last output handshake
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_q;
  logic [15:0]         beats_q;
  logic [15:0]         in_cnt_q;
  logic [15:0]         out_cnt_q;
  logic [AW-1:0]       ch_cnt_q;
  logic [AW:0]         ch_num_q;
  logic [AW:0]         ch_nxt;
  logic signed [5:0]   sh_q;
  logic [3:0]          rbp_q;
  logic [1:0]          act_q;
  logic                bias_en_q;
  logic                done_q;

  logic [BIAS_W-1:0]   bias_mem [BIAS_D];

  logic                s1_v_q, s2_v_q, s3_v_q;
  logic [LANES*ACC_W-1:0] s1_acc_q;
  logic [BIAS_W-1:0]   s1_bias_q;
  logic [LANES*SW-1:0] s2_data_q;
  logic [LANES*SW-1:0] s2_d;
  logic [LANES*OUT_W-1:0] s3_data_q;
  logic [LANES*OUT_W-1:0] s3_d;

  logic adv1, adv2, adv3;
  logic in_fire, out_fire, last_out;

  assign adv3     = !s3_v_q || out_ready_i;
  assign adv2     = !s2_v_q || adv3;
  assign adv1     = !s1_v_q || adv2;
  assign in_ready_o  = (state_q == RUN) && adv1 && (in_cnt_q < beats_q);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = s3_v_q;
  assign out_data_o  = s3_data_q;
  assign out_fire    = s3_v_q && out_ready_i;
  assign last_out    = (state_q == DRAIN) && out_fire && (out_cnt_q == beats_q - 16'd1);
  assign done_o      = done_q || (rstn && last_out);
  assign busy_o      = (state_q != IDLE);
  assign ch_nxt      = {1'b0, ch_cnt_q} + {{AW{1'b0}}, 1'b1};

  function automatic logic [SW-1:0] requant(input logic [ACC_W-1:0] acc,
                                            input logic [BIAS_W-1:0] bias,
                                            input logic signed [5:0] sh);
    logic signed [WW-1:0] wide, one, x;
    logic [5:0] amt;
    wide = $signed({{(WW-ACC_W){acc[ACC_W-1]}}, acc})
         + $signed({{(WW-BIAS_W){bias[BIAS_W-1]}}, bias});
    one  = {{(WW-1){1'b0}}, 1'b1};
    amt  = '0;
    if (sh > 6'sd0) begin
      amt = sh;
      x   = (wide + (one <<< (amt - 6'd1))) >>> amt;
    end else if (sh < 6'sd0) begin
      amt = 6'(-sh);
      x   = wide <<< amt;
    end else begin
      x = wide;
    end
    if (x[WW-1:SW-1] == {(WW-SW+1){x[WW-1]}}) return x[SW-1:0];
    return x[WW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
  endfunction

  function automatic logic [OUT_W-1:0] activate(input logic [SW-1:0] xin,
                                                input logic [1:0] mode,
                                                input logic [3:0] rbp);
    logic signed [SW-1:0] x, y, cap;
    x   = $signed(xin);
    cap = SW'(6) << rbp;
    case (mode)
      2'd0: y = x;
      2'd1: y = x[SW-1] ? '0 : x;
      2'd2: y = x[SW-1] ? (x >>> 3) : x;
      default: begin
        y = x[SW-1] ? '0 : x;
        if (y > cap) y = cap;
      end
    endcase
    if (y[SW-1:OUT_W-1] == {(SW-OUT_W+1){y[SW-1]}}) return y[OUT_W-1:0];
    return y[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    s2_d = '0;
    s3_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_d[i*SW +: SW]       = requant(s1_acc_q[i*ACC_W +: ACC_W], s1_bias_q, sh_q);
      s3_d[i*OUT_W +: OUT_W] = activate(s2_data_q[i*SW +: SW], act_q, rbp_q);
    end
  end

  // Table contents survive reset; a same-cycle write to the read index yields old data.
  always_ff @(posedge clk) begin
    if (bias_we_i) bias_mem[bias_wa_i] <= bias_wd_i;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      beats_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ch_cnt_q  <= '0;
      ch_num_q  <= '0;
      sh_q      <= '0;
      rbp_q     <= '0;
      act_q     <= '0;
      bias_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_fire) out_cnt_q <= out_cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            beats_q   <= beats_i;
            ch_num_q  <= ch_num_i;
            sh_q      <= $signed({2'b00, data_bp_i}) + $signed({2'b00, weight_bp_i})
                       - $signed({2'b00, result_bp_i});
            rbp_q     <= result_bp_i;
            act_q     <= act_mode_i;
            bias_en_q <= bias_en_i;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ch_cnt_q  <= '0;
            if (beats_i == 16'd0) done_q  <= 1'b1;
            else                  state_q <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            in_cnt_q <= in_cnt_q + 16'd1;
            if (ch_nxt >= ch_num_q) ch_cnt_q <= '0;
            else                    ch_cnt_q <= ch_nxt[AW-1:0];
            if (in_cnt_q == beats_q - 16'd1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_out) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // S1 registers the raw accumulators with the bias read; the add happens on the way into S2.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_acc_q  <= '0;
      s1_bias_q <= '0;
      s2_data_q <= '0;
      s3_data_q <= '0;
    end else begin
      if (adv1) begin
        s1_v_q <= in_fire;
        if (in_fire) begin
          s1_acc_q  <= in_data_i;
          s1_bias_q <= bias_en_q ? bias_mem[ch_cnt_q] : '0;
        end
      end
      if (adv2) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) s2_data_q <= s2_d;
      end
      if (adv3) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) s3_data_q <= s3_d;
      end
    end
  end

endmodule

// File: tb/tb_bias_relu_stream.sv
// Directed bench for bias_relu_stream: reset, requantise, activation, backpressure, bias wrap.
module tb_bias_relu_stream;
  localparam int LANES = 16, ACC_W = 32, OUT_W = 16;

  logic clk = 1'b0;
  logic rstn;
  logic bias_we_i;
  logic [5:0] bias_wa_i;
  logic [31:0] bias_wd_i;
  logic [3:0] data_bp_i, weight_bp_i, result_bp_i;
  logic bias_en_i;
  logic [1:0] act_mode_i;
  logic [6:0] ch_num_i;
  logic [15:0] beats_i;
  logic start_i, in_valid_i, in_ready_o;
  logic [LANES*ACC_W-1:0] in_data_i;
  logic out_valid_o, out_ready_i;
  logic [LANES*OUT_W-1:0] out_data_o;
  logic busy_o, done_o;

  int checks = 0;
  int errors = 0;
  logic [LANES*ACC_W-1:0] in_q[$];
  logic [LANES*OUT_W-1:0] out_q[$];
  int done_cnt, done_last, hold_err;

  always #5 clk = ~clk;

  bias_relu_stream #(.LANES(16), .ACC_W(32), .OUT_W(16), .BIAS_W(32), .BIAS_D(64)) dut (
    .clk(clk), .rstn(rstn), .bias_we_i(bias_we_i), .bias_wa_i(bias_wa_i), .bias_wd_i(bias_wd_i),
    .data_bp_i(data_bp_i), .weight_bp_i(weight_bp_i), .result_bp_i(result_bp_i),
    .bias_en_i(bias_en_i), .act_mode_i(act_mode_i), .ch_num_i(ch_num_i), .beats_i(beats_i),
    .start_i(start_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o));

  function automatic logic [LANES*ACC_W-1:0] mk_beat(input logic [31:0] a, input logic [31:0] b);
    logic [LANES*ACC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ACC_W +: ACC_W] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] mk_out(input logic [15:0] a, input logic [15:0] b);
    logic [LANES*OUT_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*OUT_W +: OUT_W] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bias(input logic [5:0] a, input logic [31:0] d);
    bias_we_i = 1'b1; bias_wa_i = a; bias_wd_i = d;
    tick();
    bias_we_i = 1'b0;
  endtask

  task automatic start_job(input logic [3:0] d, input logic [3:0] w, input logic [3:0] r,
                           input logic ben, input logic [1:0] mode, input logic [6:0] ch,
                           input logic [15:0] n);
    data_bp_i = d; weight_bp_i = w; result_bp_i = r;
    bias_en_i = ben; act_mode_i = mode; ch_num_i = ch; beats_i = n;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Feeds in_q and gathers outputs into out_q; every loop is cycle-bounded.
  task automatic run_stream(input int n, input bit rnd_valid, input bit toggle_ready);
    out_q.delete();
    done_cnt = 0; done_last = 0; hold_err = 0;
    fork
      begin
        int k = 0;
        int budget = 0;
        while (k < n && budget < 2000) begin
          in_valid_i = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
          in_data_i  = in_q[k];
          @(negedge clk);
          if (in_valid_i && in_ready_o) k++;
          tick();
          budget++;
        end
        in_valid_i = 1'b0;
      end
      begin
        int got = 0;
        int budget = 0;
        bit held = 0;
        logic [LANES*OUT_W-1:0] hv;
        while (got < n && budget < 2000) begin
          out_ready_i = toggle_ready ? (budget % 2 == 0) : 1'b1;
          @(negedge clk);
          if (held && out_data_o !== hv) hold_err++;
          held = 0;
          if (done_o) done_cnt++;
          if (out_valid_o && out_ready_i) begin
            out_q.push_back(out_data_o);
            got++;
            if (got == n && done_o) done_last = 1;
          end else if (out_valid_o) begin
            held = 1; hv = out_data_o;
          end
          tick();
          budget++;
        end
        out_ready_i = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (done_o) done_cnt++;
          tick();
        end
      end
    join
  endtask

  task automatic test_reset();
    int saw;
    rstn = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_o); end
    checks++; if (out_data_o !== '0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data_o); end
    rstn = 1'b1;
    tick();
    start_job(4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 7'd1, 16'd20);
    saw = 0;
    in_data_i = mk_beat(32'd1, 32'd2); in_valid_i = 1'b1; out_ready_i = 1'b1;
    repeat (5) begin @(negedge clk); if (done_o) saw++; tick(); end
    rstn = 1'b0; in_valid_i = 1'b0;
    repeat (2) begin @(negedge clk); if (done_o) saw++; tick(); end
    rstn = 1'b1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_o); end
    repeat (4) begin @(negedge clk); if (done_o || out_valid_o) saw++; tick(); end
    checks++; if (saw !== 0) begin errors++; $display("FAIL midrst_no_done got %0d events want 0", saw); end
  endtask

  task automatic test_basic();
    logic [LANES*ACC_W-1:0] v;
    logic [LANES*OUT_W-1:0] e;
    int lat;
    write_bias(6'd0, 32'd16);
    for (int i = 0; i < LANES; i++) begin
      v[i*ACC_W +: ACC_W] = 32'h100 + 32'(i * 16);
      e[i*OUT_W +: OUT_W] = 16'h11 + 16'(i);
    end
    start_job(4'd4, 4'd4, 4'd4, 1'b1, 2'd1, 7'd1, 16'd1);
    out_ready_i = 1'b1; in_data_i = v; in_valid_i = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 10) begin tick(); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    checks++; if (out_data_o !== e) begin errors++; $display("FAIL basic_data got %h want %h", out_data_o, e); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done_o); end
    tick();
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_after got busy=%b done=%b valid=%b want 0 0 0", busy_o, done_o, out_valid_o); end
  endtask

  task automatic test_round_sat();
    logic [LANES*OUT_W-1:0] e[4];
    in_q.delete();
    in_q.push_back(mk_beat(-32'sd24, 32'sd24));
    in_q.push_back(mk_beat(32'h7FFFFFFF, 32'h80000000));
    e[0] = mk_out(16'hFFFF, 16'h0002);
    e[1] = mk_out(16'h7FFF, 16'h8000);
    start_job(4'd4, 4'd4, 4'd4, 1'b0, 2'd0, 7'd1, 16'd2);
    run_stream(2, 1'b0, 1'b0);
    checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL round_count got %0d want 2", out_q.size()); end
    for (int k = 0; k < 2 && k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== e[k]) begin errors++; $display("FAIL round_beat%0d got %h want %h", k, out_q[k], e[k]); end
    end
    // sh = 0+0-2 = -2: left shift by 2
    in_q.delete();
    in_q.push_back(mk_beat(32'sd3, -32'sd3));
    in_q.push_back(mk_beat(32'h40000000, 32'hC0000000));
    e[2] = mk_out(16'd12, 16'hFFF4);
    e[3] = mk_out(16'h7FFF, 16'h8000);
    start_job(4'd0, 4'd0, 4'd2, 1'b0, 2'd0, 7'd1, 16'd2);
    run_stream(2, 1'b0, 1'b0);
    checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL lshift_count got %0d want 2", out_q.size()); end
    for (int k = 0; k < 2 && k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== e[k+2]) begin errors++; $display("FAIL lshift_beat%0d got %h want %h", k, out_q[k], e[k+2]); end
    end
  endtask

  task automatic test_activation();
    logic [31:0] a[3], b[3];
    logic [15:0] ea[3], eb[3];
    a[0] = -32'sd64; b[0] = 32'sd64;  ea[0] = 16'd0;    eb[0] = 16'd64;
    a[1] = -32'sd64; b[1] = -32'sd65; ea[1] = 16'hFFF8; eb[1] = 16'hFFF7;
    a[2] = 32'sd200; b[2] = -32'sd5;  ea[2] = 16'd96;   eb[2] = 16'd0;
    for (int m = 0; m < 3; m++) begin
      in_q.delete();
      in_q.push_back(mk_beat(a[m], b[m]));
      start_job(4'd2, 4'd2, 4'd4, 1'b0, 2'(m + 1), 7'd1, 16'd1);
      run_stream(1, 1'b0, 1'b0);
      checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL act_mode%0d_count got %0d want 1", m + 1, out_q.size()); end
      else begin
        checks++; if (out_q[0] !== mk_out(ea[m], eb[m])) begin errors++;
          $display("FAIL act_mode%0d_data got %h want %h", m + 1, out_q[0], mk_out(ea[m], eb[m])); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [LANES*OUT_W-1:0] e[8];
    in_q.delete();
    for (int k = 0; k < 8; k++) begin
      in_q.push_back(mk_beat(32'(k * 7 - 20), 32'(k)));
      e[k] = mk_out(16'(k * 7 - 20), 16'(k));
    end
    start_job(4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 7'd1, 16'd8);
    run_stream(8, 1'b1, 1'b1);
    checks++; if (out_q.size() !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", out_q.size()); end
    for (int k = 0; k < 8 && k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== e[k]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", k, out_q[k], e[k]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
    checks++; if (done_last !== 1) begin errors++; $display("FAIL bp_done_on_last got %0d want 1", done_last); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", hold_err); end
  endtask

  task automatic test_bias_wrap();
    logic [15:0] ev[7];
    for (int k = 0; k < 4; k++) write_bias(6'(k), 32'(k * 100 + (k == 3 ? 899 : 0)));
    ev = '{16'd0, 16'd100, 16'd200, 16'd0, 16'd100, 16'd200, 16'd0};
    in_q.delete();
    for (int k = 0; k < 7; k++) in_q.push_back(mk_beat(32'd0, 32'd0));
    start_job(4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 7'd3, 16'd7);
    run_stream(7, 1'b0, 1'b0);
    checks++; if (out_q.size() !== 7) begin errors++; $display("FAIL wrap_count got %0d want 7", out_q.size()); end
    for (int k = 0; k < 7 && k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== mk_out(ev[k], ev[k])) begin errors++;
        $display("FAIL wrap_beat%0d got %h want %h", k, out_q[k], mk_out(ev[k], ev[k])); end
    end
    start_job(4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 7'd1, 16'd0);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_beats_done got %b want 1", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_beats_busy got %b want 0", busy_o); end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_beats_pulse got %b want 0", done_o); end
  endtask

  initial begin
    rstn = 1'b0; bias_we_i = 1'b0; bias_wa_i = '0; bias_wd_i = '0;
    data_bp_i = '0; weight_bp_i = '0; result_bp_i = '0; bias_en_i = 1'b0; act_mode_i = '0;
    ch_num_i = 7'd1; beats_i = '0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    out_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_round_sat();
    test_activation();
    test_back_to_back();
    test_bias_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
